// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave backed by an internal byte-addressable memory, one outstanding burst per direction.
// Optional EI_AXI4_SLV_ERR_RESP_EN: out-of-range beats and wlast mismatches answer SLVERR instead of wrapping modulo MEM_BYTES.
module ei_axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int LANES   = DATA_WIDTH / 8;
    localparam int LANE_LG = $clog2(LANES);
    localparam int MEM_LG  = $clog2(MEM_BYTES);
    localparam int WORDS   = MEM_BYTES / LANES;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [2:0]            sz;
        logic [ADDR_WIDTH-1:0] bytes, incr, span;
        sz    = (size > 3'(LANE_LG)) ? 3'(LANE_LG) : size;
        bytes = A_ONE << sz;
        incr  = (addr & ~(bytes - A_ONE)) + bytes;
        span  = bytes * (ADDR_WIDTH'(len) + A_ONE);
        case (burst)
            2'd0:    next_addr = addr;
            2'd2:    if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                         next_addr = (addr & ~(span - A_ONE)) + (incr & (span - A_ONE));
                     else
                         next_addr = incr;
            default: next_addr = incr;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    wstate_t               r_wstate, w_wstate_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_awlen, r_wcnt;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst, r_bresp;
    logic                  r_werr, r_awready, r_wready, r_bvalid;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_wbeat_last, w_wbeat_err, w_wr_en;
    logic [MEM_LG-LANE_LG-1:0] w_widx, w_ridx;

    rstate_t               r_rstate, w_rstate_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr, w_rd_addr;
    logic [7:0]            r_arlen, r_rcnt;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst, r_rresp;
    logic                  r_arready, r_rvalid, r_rlast, w_ar_hs, w_r_hs, w_rd_ok;
    logic [DATA_WIDTH-1:0] r_rdata, w_rd_word;

    assign w_aw_hs      = awvalid && r_awready;
    assign w_w_hs       = wvalid && r_wready;
    assign w_b_hs       = bready && r_bvalid;
    assign w_wbeat_last = (r_wcnt == r_awlen);
    assign w_widx       = r_waddr[MEM_LG-1:LANE_LG];

    assign w_ar_hs   = arvalid && r_arready;
    assign w_r_hs    = rready && r_rvalid;
    // In IDLE the first beat is fetched from the incoming address so rdata is ready one cycle after AR.
    assign w_rd_addr = (r_rstate == R_IDLE) ? araddr
                                            : next_addr(r_raddr, r_arlen, r_arsize, r_arburst);
    assign w_ridx    = w_rd_addr[MEM_LG-1:LANE_LG];
    assign w_rd_word = w_rd_ok ? r_mem[w_ridx] : '0;

`ifdef EI_AXI4_SLV_ERR_RESP_EN
    logic w_wr_oor;
    assign w_wr_oor    = (r_waddr >= ADDR_WIDTH'(MEM_BYTES));
    assign w_wbeat_err = w_wr_oor || (wlast != w_wbeat_last);
    assign w_wr_en     = w_w_hs && !w_wr_oor;
    assign w_rd_ok     = (w_rd_addr < ADDR_WIDTH'(MEM_BYTES));
`else
    logic w_unused;
    assign w_wbeat_err = 1'b0;
    assign w_wr_en     = w_w_hs;
    assign w_rd_ok     = 1'b1;
    assign w_unused    = ^{wlast, w_rd_addr};
`endif

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wbeat_last) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_waddr   <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_waddr   <= awaddr;
                r_awlen   <= awlen;
                r_awsize  <= awsize;
                r_awburst <= awburst;
                r_wcnt    <= '0;
                r_werr    <= 1'b0;
            end else if (w_w_hs) begin
                r_waddr <= next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
                r_wcnt  <= r_wcnt + 8'd1;
                r_werr  <= r_werr | w_wbeat_err;
                if (w_wbeat_last)
                    r_bresp <= (r_werr || w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb[i]) r_mem[w_widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
            r_raddr   <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_raddr   <= araddr;
                r_arlen   <= arlen;
                r_arsize  <= arsize;
                r_arburst <= arburst;
                r_rcnt    <= '0;
                r_rdata   <= w_rd_word;
                r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_rlast   <= (arlen == 8'd0);
            end else if (w_r_hs && !r_rlast) begin
                r_raddr <= w_rd_addr;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rdata <= w_rd_word;
                r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Scoreboard bench for ei_axi4_slave_mem: word model plus expected-beat queues popped as R beats complete.
module tb_ei_axi4_slave_mem;
    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];
    logic [31:0] sb_data[$];
    logic        sb_last[$];
    logic [1:0]  sb_resp[$];

    ei_axi4_slave_mem dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] addr_of(input logic [31:0] a, input logic [1:0] b, input int len, input int i);
        logic [31:0] al, span;
        al = a & ~32'h3;
        if (b == 2'd0) return a;
        if (b == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            span = 32'(4 * (len + 1));
            return (a & ~(span - 32'd1)) + ((al + 32'(4 * i)) % span);
        end
        return al + 32'(4 * i);
    endfunction

    function automatic bit oor(input logic [31:0] a);
`ifdef EI_AXI4_SLV_ERR_RESP_EN
        return a >= 32'd4096;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        logic [31:0] w;
        k = int'((a & 32'hFFF) >> 2);
        w = model.exists(k) ? model[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[k] = w;
    endtask

    task automatic wpush(input logic [31:0] d, input logic [3:0] s);
        wq_data.push_back(d);
        wq_strb.push_back(s);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input int bstall, input logic [1:0] exp_resp, input int bad_last);
        int n;
        logic [31:0] a;
        awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL aw_to_wready: got %b want 1", wready); end
        for (int i = 0; i <= len; i++) begin
            wdata = wq_data.pop_front();
            wstrb = wq_strb.pop_front();
            wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
            wvalid = 1'b1;
            a = addr_of(addr, burst, len, i);
            if (!oor(a)) model_write(a, wdata, wstrb);
            n = 0;
            while (!wready && n < 50) begin @(posedge aclk); #1; n++; end
            if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout: beat %0d wready stuck at 0", i); end
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_after_last: got %b want 1", bvalid); end
        repeat (bstall) begin
            @(posedge aclk); #1;
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                errors++; $display("FAIL b_stall_hold: bvalid=%b awready=%b want 1/0", bvalid, awready);
            end
        end
        checks++;
        if (bresp !== exp_resp) begin errors++; $display("FAIL bresp: got %0d want %0d", bresp, exp_resp); end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL b_done: awready=%b bvalid=%b want 1/0", awready, bvalid);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst, input int stall_beat);
        int n, k;
        logic [31:0] a, ed;
        logic el;
        logic [1:0] er;
        for (int i = 0; i <= len; i++) begin
            a = addr_of(addr, burst, len, i);
            k = int'((a & 32'hFFF) >> 2);
            sb_data.push_back(oor(a) ? 32'h0 : (model.exists(k) ? model[k] : 32'hx));
            sb_last.push_back(i == len);
            sb_resp.push_back(oor(a) ? 2'd2 : 2'd0);
        end
        araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL ar_to_rvalid: got %b want 1", rvalid); end
        rready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(posedge aclk); #1; n++; end
            if (n >= 50) begin checks++; errors++; $display("FAIL r_timeout: beat %0d rvalid stuck at 0", i); end
            if (i == stall_beat) begin
                rready = 1'b0;
                repeat (3) begin
                    @(posedge aclk); #1;
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== sb_data[0] || rlast !== sb_last[0]) begin
                        errors++;
                        $display("FAIL r_stall_hold: rvalid=%b rdata=%h rlast=%b want 1/%h/%b",
                                 rvalid, rdata, rlast, sb_data[0], sb_last[0]);
                    end
                end
                rready = 1'b1;
            end
            ed = sb_data.pop_front(); el = sb_last.pop_front(); er = sb_resp.pop_front();
            checks++;
            if (rdata !== ed || rlast !== el || rresp !== er) begin
                errors++;
                $display("FAIL r_beat%0d: rdata=%h rlast=%b rresp=%0d want %h/%b/%0d", i, rdata, rlast, rresp, ed, el, er);
            end
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL r_done: arready=%b rvalid=%b want 1/0", arready, rvalid);
        end
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0 ||
            rdata !== 32'h0 || rlast !== 1'b0 || bresp !== 2'd0 || rresp !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: awr=%b arr=%b wr=%b bv=%b rv=%b rd=%h rl=%b br=%0d rr=%0d",
                     awready, arready, wready, bvalid, rvalid, rdata, rlast, bresp, rresp);
        end
    endtask

    task automatic test_incr;
        wpush(32'h11111111, 4'hF); wpush(32'h22222222, 4'hF);
        wpush(32'h33333333, 4'hF); wpush(32'h44444444, 4'hF);
        do_write(32'h100, 3, 2'd1, 5, 2'd0, -1);
        do_read(32'h100, 3, 2'd1, -1);
    endtask

    task automatic test_wrap;
        do_read(32'h108, 3, 2'd2, -1);
    endtask

    task automatic test_fixed;
        wpush(32'h0, 4'hF);
        do_write(32'h40, 0, 2'd1, 0, 2'd0, -1);
        wpush(32'h000000AA, 4'h1); wpush(32'h0000BB00, 4'h2); wpush(32'h00CC0000, 4'h4);
        do_write(32'h40, 2, 2'd0, 0, 2'd0, -1);
        do_read(32'h40, 0, 2'd1, -1);
    endtask

    task automatic test_backpressure;
        do_read(32'h100, 3, 2'd1, 2);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) wpush($urandom, 4'(1 + $urandom_range(0, 14)));
        do_write(32'h300, 7, 2'd1, 0, 2'd0, -1);
        wpush($urandom, 4'hF); wpush($urandom, 4'hF);
        do_write(32'h320, 1, 2'd1, 0, 2'd0, -1);
        do_read(32'h300, 7, 2'd1, -1);
        do_read(32'h320, 1, 2'd1, -1);
    endtask

    task automatic test_reset_abort;
        int n;
        awaddr = 32'h200; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hA0A0_0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            model_write(32'h200 + 32'(4 * i), wdata, wstrb);
            @(posedge aclk); #1;
        end
        wdata = 32'hDEAD0002;
        areset = 1'b1;
        #1;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL abort_now: wready=%b awready=%b bvalid=%b want 0/1/0", wready, awready, bvalid);
        end
        @(posedge aclk); #1;
        areset = 1'b0; wvalid = 1'b0;
        repeat (3) begin
            @(posedge aclk); #1;
            checks++;
            if (bvalid !== 1'b0 || awready !== 1'b1) begin
                errors++; $display("FAIL abort_no_b: bvalid=%b awready=%b want 0/1", bvalid, awready);
            end
        end
        do_read(32'h200, 1, 2'd1, -1);
    endtask

`ifdef EI_AXI4_SLV_ERR_RESP_EN
    task automatic test_err_resp;
        wpush(32'h5A5A5A5A, 4'hF);
        do_write(32'h0, 0, 2'd1, 0, 2'd0, -1);
        wpush(32'hDEADBEEF, 4'hF);
        do_write(32'h1000, 0, 2'd1, 0, 2'd2, -1);
        do_read(32'h0, 0, 2'd1, -1);
        do_read(32'h1000, 0, 2'd1, -1);
        for (int i = 0; i < 4; i++) wpush(32'h7700 + 32'(i), 4'hF);
        do_write(32'h20, 3, 2'd1, 0, 2'd2, 1);
        do_read(32'h20, 3, 2'd1, -1);
    endtask
`endif

    initial begin
        areset = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset;
        test_incr;
        test_wrap;
        test_fixed;
        test_backpressure;
        test_back_to_back;
        test_reset_abort;
`ifdef EI_AXI4_SLV_ERR_RESP_EN
        test_err_resp;
`endif
        checks++;
        if (sb_data.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d beats never seen", sb_data.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
